// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcode/funct
// values, datapath select codes and the control-bundle struct.
package mc_ctrl_pkg;

  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EX_R   = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_EX_I   = 4'd4;
  localparam logic [3:0] S_WB_I   = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_WB_LW  = 4'd9;
  localparam logic [3:0] S_BEQ    = 4'd10;
  localparam logic [3:0] S_J      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ext_zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// Combinational op/funct decoder: ALU operation for the execute states and a flag
// telling whether the instruction is one the FSM supports.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_ANDI:                                  alu_ctrl_o = ALU_AND;
      OP_ORI:                                   alu_ctrl_o = ALU_OR;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J:      alu_ctrl_o = ALU_ADD;
      default:                                  legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/ALU/regfile/memory per instruction
// and counts retired instructions.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int RET_CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_wr,
  output logic                 ir_wr,
  output logic                 iord,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 reg_wr,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 ext_zero,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_ctrl,
  output logic [1:0]           pc_src,
  output logic                 illegal,
  output logic [3:0]           state_o,
  output logic [RET_CNT_W-1:0] ret_cnt
);

  logic [3:0]           state_q, state_d;
  logic [RET_CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic                 ready_s;
  logic                 retire_s;
  logic [2:0]           dec_alu_s;
  logic                 dec_legal_s;
  ctrl_t                ctrl_s;
  ctrl_t                out_s;

  assign ready_s = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  mc_alu_dec u_alu_dec (
    .op_i       (op),
    .funct_i    (funct),
    .alu_ctrl_o (dec_alu_s),
    .legal_o    (dec_legal_s)
  );

  always_comb begin
    state_d  = S_IF;
    retire_s = 1'b0;
    ctrl_s   = '0;
    case (state_q)
      S_IF: begin
        ctrl_s.mem_rd    = 1'b1;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_ctrl  = ALU_ADD;
        ctrl_s.pc_wr     = ready_s;
        ctrl_s.ir_wr     = ready_s;
        state_d          = ready_s ? S_ID : S_IF;
      end
      S_ID: begin
        ctrl_s.alu_src_b = SRCB_BR;
        ctrl_s.alu_ctrl  = ALU_ADD;
        ctrl_s.illegal   = ~dec_legal_s;
        if (dec_legal_s) begin
          case (op)
            OP_RTYPE:                  state_d = S_EX_R;
            OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EX_I;
            OP_LW, OP_SW:              state_d = S_ADDR;
            OP_BEQ:                    state_d = S_BEQ;
            OP_J:                      state_d = S_J;
            default:                   state_d = S_IF;
          endcase
        end else begin
          state_d = S_IF;
        end
      end
      S_EX_R: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REG;
        ctrl_s.alu_ctrl  = dec_alu_s;
        state_d          = S_WB_R;
      end
      S_WB_R: begin
        ctrl_s.reg_wr  = 1'b1;
        ctrl_s.reg_dst = 1'b1;
        retire_s       = 1'b1;
      end
      S_EX_I: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_ctrl  = dec_alu_s;
        ctrl_s.ext_zero  = (op != OP_ADDI);
        state_d          = S_WB_I;
      end
      S_WB_I: begin
        ctrl_s.reg_wr = 1'b1;
        retire_s      = 1'b1;
      end
      S_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_ctrl  = ALU_ADD;
        state_d          = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl_s.iord   = 1'b1;
        ctrl_s.mem_rd = 1'b1;
        state_d       = ready_s ? S_WB_LW : S_MEM_RD;
      end
      S_MEM_WR: begin
        ctrl_s.iord   = 1'b1;
        ctrl_s.mem_wr = 1'b1;
        retire_s      = ready_s;
        state_d       = ready_s ? S_IF : S_MEM_WR;
      end
      S_WB_LW: begin
        ctrl_s.reg_wr     = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        retire_s          = 1'b1;
      end
      S_BEQ: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REG;
        ctrl_s.alu_ctrl  = ALU_SUB;
        ctrl_s.pc_src    = PCSRC_OUT;
        ctrl_s.pc_wr     = zero;
        retire_s         = 1'b1;
      end
      S_J: begin
        ctrl_s.pc_wr  = 1'b1;
        ctrl_s.pc_src = PCSRC_JMP;
        retire_s      = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
    ret_cnt_d = retire_s ? (ret_cnt_q + RET_CNT_W'(1)) : ret_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Reset masks every strobe combinationally so an in-flight access cannot complete.
  assign out_s      = rst ? '0 : ctrl_s;
  assign pc_wr      = out_s.pc_wr;
  assign ir_wr      = out_s.ir_wr;
  assign iord       = out_s.iord;
  assign mem_rd     = out_s.mem_rd;
  assign mem_wr     = out_s.mem_wr;
  assign reg_wr     = out_s.reg_wr;
  assign reg_dst    = out_s.reg_dst;
  assign mem_to_reg = out_s.mem_to_reg;
  assign ext_zero   = out_s.ext_zero;
  assign alu_src_a  = out_s.alu_src_a;
  assign alu_src_b  = out_s.alu_src_b;
  assign alu_ctrl   = out_s.alu_ctrl;
  assign pc_src     = out_s.pc_src;
  assign illegal    = out_s.illegal;
  assign state_o    = state_q;
  assign ret_cnt    = ret_cnt_q;

endmodule
